// File: rtl/r5p_bus_rsp_if.sv
// Request/response bus between an initiator (master) and a memory responder (slave).
// Handshake: a transfer completes in the cycle where vld & rdy are both 1; rdt/err answer on the following edge.
interface r5p_bus_rsp_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int BW = DW/8
) ();
   logic          vld;
   logic          wen;
   logic [AW-1:0] adr;
   logic [BW-1:0] ben;
   logic [DW-1:0] wdt;
   logic [DW-1:0] rdt;
   logic          rdy;
   logic          err;

   modport master (output vld, wen, adr, ben, wdt, input rdt, rdy, err);
   modport slave  (input vld, wen, adr, ben, wdt, output rdt, rdy, err);
endinterface

// File: rtl/r5p_bus_rsp.sv
// Single-port byte-writable memory responder with optional fixed wait states.
// dbg_state exposes the wait FSM (0 = IDLE, 1 = CNT, 2 = ACK); it is always 0 when WAIT = 0.
module r5p_bus_rsp #(
   parameter int AW   = 32,
   parameter int DW   = 32,
   parameter int BW   = DW/8,
   parameter int SIZE = 4096,
   parameter int WAIT = 0
) (
   input  logic             clk,
   input  logic             rst,
   r5p_bus_rsp_if.slave     bus,
   output logic [1:0]       dbg_state
);
   localparam int AL    = $clog2(SIZE);
   localparam int BL    = $clog2(BW);
   localparam int WORDS = SIZE/BW;

   logic [DW-1:0]    mem [WORDS];
   logic [AL-BL-1:0] idx;
   logic             oor;
   logic             xfer;
   logic [DW-1:0]    rdt_q;
   logic             err_q;

   assign idx  = bus.adr[AL-1:BL];
   assign oor  = (bus.adr >= AW'(SIZE));
   assign xfer = bus.vld & bus.rdy;

   generate
      if (WAIT == 0) begin : g_nowait
         assign bus.rdy   = ~rst;
         assign dbg_state = 2'd0;
      end else begin : g_wait
         typedef enum logic [1:0] {IDLE = 2'd0, CNT = 2'd1, ACK = 2'd2} state_t;
         state_t     state;
         logic [3:0] cnt;
         logic       rdy_q;

         // rdy_q is set exactly when the next state is ACK, so it mirrors state == ACK.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state <= IDLE;
               cnt   <= '0;
               rdy_q <= 1'b0;
            end else begin
               rdy_q <= 1'b0;
               case (state)
                  IDLE: begin
                     if (bus.vld) begin
                        state <= CNT;
                        cnt   <= 4'(WAIT-1);
                     end
                  end
                  CNT: begin
                     if (!bus.vld) begin
                        state <= IDLE;
                        cnt   <= '0;
                     end else if (cnt == 4'd0) begin
                        state <= ACK;
                        rdy_q <= 1'b1;
                     end else begin
                        cnt <= cnt - 4'd1;
                     end
                  end
                  ACK: begin
                     if (bus.vld) begin
                        state <= CNT;
                        cnt   <= 4'(WAIT-1);
                     end else begin
                        state <= IDLE;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end

         assign bus.rdy   = rdy_q;
         assign dbg_state = state;
      end
   endgenerate

   // Memory array has no reset; rst gating keeps an in-flight transfer from writing.
   always_ff @(posedge clk) begin
      if (!rst && xfer && bus.wen && !oor) begin
         for (int b = 0; b < BW; b++) begin
            if (bus.ben[b]) mem[idx][8*b +: 8] <= bus.wdt[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdt_q <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= xfer & oor;
         if (xfer && !bus.wen) rdt_q <= oor ? '0 : mem[idx];
      end
   end

   assign bus.rdt = rdt_q;
   assign bus.err = err_q;
endmodule

// File: tb/tb_r5p_bus_rsp.sv
// Bench for r5p_bus_rsp: one zero-wait and one WAIT=3 instance checked against a word-level memory model.
module tb_r5p_bus_rsp;
   localparam int AW = 32, DW = 32, BW = 4, SIZE = 4096, W3 = 3;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   r5p_bus_rsp_if #(.AW(AW), .DW(DW), .BW(BW)) b0 ();
   r5p_bus_rsp_if #(.AW(AW), .DW(DW), .BW(BW)) b3 ();
   logic [1:0] st0, st3;

   r5p_bus_rsp #(.AW(AW), .DW(DW), .BW(BW), .SIZE(SIZE), .WAIT(0)) dut0 (
      .clk(clk), .rst(rst), .bus(b0), .dbg_state(st0));
   r5p_bus_rsp #(.AW(AW), .DW(DW), .BW(BW), .SIZE(SIZE), .WAIT(W3)) dut3 (
      .clk(clk), .rst(rst), .bus(b3), .dbg_state(st3));

   int n_cmp = 0;
   int n_fail = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] m0 [int];
   logic [DW-1:0] m3 [int];
   logic [DW-1:0] last3 = '0;

   // reference model: word-indexed memory, out-of-range writes dropped, reads return 0
   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wdt,
                                           input logic [BW-1:0] ben);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < BW; b++) if (ben[b]) r[8*b +: 8] = wdt[8*b +: 8];
      return r;
   endfunction

   function automatic void model_wr(input bit which, input logic [AW-1:0] adr,
                                    input logic [BW-1:0] ben, input logic [DW-1:0] wdt);
      int k;
      if (adr >= SIZE) return;
      k = int'(adr / BW);
      if (which) m3[k] = merge(m3.exists(k) ? m3[k] : 'x, wdt, ben);
      else       m0[k] = merge(m0.exists(k) ? m0[k] : 'x, wdt, ben);
   endfunction

   function automatic logic [DW-1:0] model_rd(input bit which, input logic [AW-1:0] adr);
      int k;
      if (adr >= SIZE) return '0;
      k = int'(adr / BW);
      if (which) return m3.exists(k) ? m3[k] : 'x;
      return m0.exists(k) ? m0[k] : 'x;
   endfunction

   // driver tasks: entered and left at posedge+1
   task automatic drv0(input logic wen, input logic [AW-1:0] adr, input logic [BW-1:0] ben,
                       input logic [DW-1:0] wdt, output logic rdy_seen);
      b0.vld = 1'b1; b0.wen = wen; b0.adr = adr; b0.ben = ben; b0.wdt = wdt;
      @(negedge clk); rdy_seen = b0.rdy;
      @(posedge clk); #1; b0.vld = 1'b0;
   endtask

   task automatic drv3(input logic wen, input logic [AW-1:0] adr, input logic [BW-1:0] ben,
                       input logic [DW-1:0] wdt, input bit wiggle, output int lat);
      b3.vld = 1'b1; b3.wen = wen; b3.adr = adr; b3.ben = ben; b3.wdt = wdt;
      lat = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (b3.rdy) begin lat = c; break; end
         @(posedge clk); #1;
         if (wiggle && c == 0) begin b3.adr = adr ^ 32'h100; b3.ben = ~ben; b3.wdt = $urandom; b3.wen = ~wen; end
         if (wiggle && c == 1) begin b3.adr = adr; b3.ben = ben; b3.wdt = wdt; b3.wen = wen; end
      end
      @(posedge clk); #1; b3.vld = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset;
      idle(3);
      @(negedge clk);
      n_cmp++; if (b0.rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy0: got %b want 0", b0.rdy); end
      n_cmp++; if (b3.rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy3: got %b want 0", b3.rdy); end
      n_cmp++; if (b0.rdt !== 32'h0) begin n_fail++; $display("FAIL reset_rdt0: got %h want 0", b0.rdt); end
      n_cmp++; if (b3.rdt !== 32'h0) begin n_fail++; $display("FAIL reset_rdt3: got %h want 0", b3.rdt); end
      n_cmp++; if ({b0.err, b3.err} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", {b0.err, b3.err}); end
      n_cmp++; if ({st0, st3} !== 4'h0) begin n_fail++; $display("FAIL reset_state: got %h want 0", {st0, st3}); end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (b0.rdy !== 1'b1) begin n_fail++; $display("FAIL release_rdy0: got %b want 1", b0.rdy); end
      n_cmp++; if (b3.rdy !== 1'b0) begin n_fail++; $display("FAIL release_rdy3: got %b want 0", b3.rdy); end
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      logic r;
      drv0(1'b1, 32'h10, 4'hF, 32'hA5A5_1234, r); model_wr(0, 32'h10, 4'hF, 32'hA5A5_1234);
      n_cmp++; if (r !== 1'b1) begin n_fail++; $display("FAIL basic_wr_rdy: got %b want 1", r); end
      drv0(1'b0, 32'h10, 4'h0, 32'h0, r);
      n_cmp++; if (r !== 1'b1) begin n_fail++; $display("FAIL basic_rd_rdy: got %b want 1", r); end
      n_cmp++; if (b0.rdt !== 32'hA5A5_1234) begin n_fail++; $display("FAIL basic_rdt: got %h want a5a51234", b0.rdt); end
   endtask

   task automatic test_byte_enable;
      logic r;
      drv0(1'b1, 32'h20, 4'hF, 32'h1122_3344, r); model_wr(0, 32'h20, 4'hF, 32'h1122_3344);
      drv0(1'b1, 32'h20, 4'b0101, 32'hFFFF_FFFF, r); model_wr(0, 32'h20, 4'b0101, 32'hFFFF_FFFF);
      drv0(1'b0, 32'h20, 4'h0, 32'h0, r);
      n_cmp++; if (b0.rdt !== 32'h11FF_33FF) begin n_fail++; $display("FAIL ben_rdt: got %h want 11ff33ff", b0.rdt); end
      drv0(1'b1, 32'h20, 4'hF, 32'h0, r); model_wr(0, 32'h20, 4'hF, 32'h0);
      idle(2);
      n_cmp++; if (b0.rdt !== 32'h11FF_33FF) begin n_fail++; $display("FAIL rdt_hold: got %h want 11ff33ff", b0.rdt); end
   endtask

   task automatic test_out_of_range;
      logic r;
      drv0(1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, r); model_wr(0, 32'h0, 4'hF, 32'hCAFE_F00D);
      drv0(1'b1, 32'h1000, 4'hF, 32'hDEAD_BEEF, r); model_wr(0, 32'h1000, 4'hF, 32'hDEAD_BEEF);
      n_cmp++; if (b0.err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b want 1", b0.err); end
      drv0(1'b0, 32'h1000, 4'hF, 32'h0, r);
      n_cmp++; if (b0.rdt !== 32'h0) begin n_fail++; $display("FAIL oor_rdt: got %h want 0", b0.rdt); end
      n_cmp++; if (b0.err !== 1'b1) begin n_fail++; $display("FAIL oor_rd_err: got %b want 1", b0.err); end
      idle(1);
      n_cmp++; if (b0.err !== 1'b0) begin n_fail++; $display("FAIL oor_err_pulse: got %b want 0", b0.err); end
      drv0(1'b0, 32'h0, 4'hF, 32'h0, r);
      n_cmp++; if (b0.rdt !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL oor_alias: got %h want cafef00d", b0.rdt); end
   endtask

   task automatic test_random_w0;
      logic r;
      logic [AW-1:0] adr;
      logic [BW-1:0] ben;
      logic [DW-1:0] wdt, exp;
      bit oor;
      for (int i = 0; i < 16; i++) begin
         wdt = $urandom; drv0(1'b1, 32'h100 + 4*i, 4'hF, wdt, r); model_wr(0, 32'h100 + 4*i, 4'hF, wdt);
      end
      for (int i = 0; i < 40; i++) begin
         oor = ($urandom_range(0, 7) == 0);
         adr = (oor ? SIZE : 32'h100) + 4*$urandom_range(0, 15) + $urandom_range(0, 3);
         ben = 4'($urandom_range(0, 15)); wdt = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            model_wr(0, adr, ben, wdt);
            drv0(1'b1, adr, ben, wdt, r);
         end else begin
            exp_q.push_back(model_rd(0, adr));
            drv0(1'b0, adr, ben, wdt, r);
            exp = exp_q.pop_front();
            n_cmp++; if (b0.rdt !== exp) begin n_fail++; $display("FAIL rnd0_rdt[%0d]: got %h want %h", i, b0.rdt, exp); end
         end
         n_cmp++; if (b0.err !== oor) begin n_fail++; $display("FAIL rnd0_err[%0d]: got %b want %b", i, b0.err, oor); end
         idle($urandom_range(0, 2));
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      logic [DW-1:0] va, vb;
      logic [9:0] rdy_v;
      va = $urandom; vb = $urandom;
      drv3(1'b1, 32'h40, 4'hF, va, 1'b0, lat); model_wr(1, 32'h40, 4'hF, va); idle(1);
      n_cmp++; if (lat !== W3+1) begin n_fail++; $display("FAIL b2b_pre_lat: got %0d want %0d", lat, W3+1); end
      drv3(1'b1, 32'h44, 4'hF, vb, 1'b0, lat); model_wr(1, 32'h44, 4'hF, vb); idle(1);
      b3.vld = 1'b1; b3.wen = 1'b0; b3.adr = 32'h40; b3.ben = 4'h0; b3.wdt = '0;
      rdy_v = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         rdy_v[c] = b3.rdy;
         if (c == 4) begin n_cmp++; if (b3.rdt !== last3) begin n_fail++; $display("FAIL b2b_rdt_c4: got %h want %h", b3.rdt, last3); end end
         if (c == 5) begin n_cmp++; if (b3.rdt !== model_rd(1, 32'h40)) begin n_fail++; $display("FAIL b2b_rdt_c5: got %h want %h", b3.rdt, va); end end
         if (c == 9) begin n_cmp++; if (b3.rdt !== model_rd(1, 32'h44)) begin n_fail++; $display("FAIL b2b_rdt_c9: got %h want %h", b3.rdt, vb); end end
         @(posedge clk); #1;
         if (c == 4) b3.adr = 32'h44;
         if (c == 8) b3.vld = 1'b0;
      end
      last3 = vb;
      n_cmp++; if (rdy_v !== 10'h110) begin n_fail++; $display("FAIL b2b_rdy_cycles: got %b want %b", rdy_v, 10'h110); end
      idle(1);
   endtask

   task automatic test_abort;
      int lat;
      logic any_rdy;
      logic [DW-1:0] v;
      v = $urandom;
      drv3(1'b1, 32'h50, 4'hF, v, 1'b0, lat); model_wr(1, 32'h50, 4'hF, v); idle(1);
      b3.vld = 1'b1; b3.wen = 1'b1; b3.adr = 32'h50; b3.ben = 4'hF; b3.wdt = ~v;
      @(negedge clk); any_rdy = b3.rdy;
      @(posedge clk); #1; b3.vld = 1'b0;
      @(negedge clk); any_rdy |= b3.rdy;
      @(negedge clk); any_rdy |= b3.rdy;
      n_cmp++; if (st3 !== 2'd0) begin n_fail++; $display("FAIL abort_idle: got state %0d want 0", st3); end
      for (int c = 0; c < 5; c++) begin @(negedge clk); any_rdy |= b3.rdy; end
      n_cmp++; if (any_rdy !== 1'b0) begin n_fail++; $display("FAIL abort_rdy: got %b want 0", any_rdy); end
      @(posedge clk); #1;
      drv3(1'b0, 32'h50, 4'hF, 32'h0, 1'b0, lat);
      n_cmp++; if (b3.rdt !== model_rd(1, 32'h50)) begin n_fail++; $display("FAIL abort_mem: got %h want %h", b3.rdt, v); end
      n_cmp++; if (lat !== W3+1) begin n_fail++; $display("FAIL abort_lat: got %0d want %0d", lat, W3+1); end
      last3 = v;
      idle(1);
   endtask

   task automatic test_random_w3;
      int lat, gap, exp_lat;
      bit oor, b2b;
      logic [AW-1:0] adr;
      logic [BW-1:0] ben;
      logic [DW-1:0] wdt, exp;
      for (int i = 0; i < 8; i++) begin
         wdt = $urandom; drv3(1'b1, 32'h200 + 4*i, 4'hF, wdt, 1'b0, lat); model_wr(1, 32'h200 + 4*i, 4'hF, wdt);
      end
      idle(1);
      b2b = 1'b0;
      for (int i = 0; i < 24; i++) begin
         oor = ($urandom_range(0, 5) == 0);
         adr = (oor ? SIZE : 32'h200) + 4*$urandom_range(0, 7) + $urandom_range(0, 3);
         ben = 4'($urandom_range(0, 15)); wdt = $urandom;
         exp_lat = b2b ? W3 : W3+1;
         if ($urandom_range(0, 1) == 1) begin
            model_wr(1, adr, ben, wdt);
            drv3(1'b1, adr, ben, wdt, ($urandom_range(0, 1) == 1), lat);
         end else begin
            exp_q.push_back(model_rd(1, adr));
            drv3(1'b0, adr, ben, wdt, ($urandom_range(0, 1) == 1), lat);
            exp = exp_q.pop_front();
            n_cmp++; if (b3.rdt !== exp) begin n_fail++; $display("FAIL rnd3_rdt[%0d]: got %h want %h", i, b3.rdt, exp); end
            last3 = exp;
         end
         n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd3_lat[%0d]: got %0d want %0d", i, lat, exp_lat); end
         n_cmp++; if (b3.err !== oor) begin n_fail++; $display("FAIL rnd3_err[%0d]: got %b want %b", i, b3.err, oor); end
         gap = $urandom_range(0, 2);
         b2b = (gap == 0);
         idle(gap);
      end
      idle(1);
   endtask

   task automatic test_reset_mid;
      int lat;
      b3.vld = 1'b1; b3.wen = 1'b0; b3.adr = 32'h44; b3.ben = 4'hF; b3.wdt = '0;
      idle(2);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if ({b3.rdy, b3.err, b0.rdy} !== 3'b000) begin n_fail++; $display("FAIL rstmid_rdy_err: got %b want 000", {b3.rdy, b3.err, b0.rdy}); end
      n_cmp++; if (b3.rdt !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdt: got %h want 0", b3.rdt); end
      n_cmp++; if (st3 !== 2'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d want 0", st3); end
      idle(2);
      rst = 1'b0;
      lat = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (b3.rdy) begin lat = c; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1; b3.vld = 1'b0;
      n_cmp++; if (lat !== W3+1) begin n_fail++; $display("FAIL rstmid_lat: got %0d want %0d", lat, W3+1); end
      n_cmp++; if (b3.rdt !== model_rd(1, 32'h44)) begin n_fail++; $display("FAIL rstmid_rdt_after: got %h want %h", b3.rdt, model_rd(1, 32'h44)); end
   endtask

   initial begin
      b0.vld = 1'b0; b0.wen = 1'b0; b0.adr = '0; b0.ben = '0; b0.wdt = '0;
      b3.vld = 1'b0; b3.wen = 1'b0; b3.adr = '0; b3.ben = '0; b3.wdt = '0;
      test_reset();
      test_basic();
      test_byte_enable();
      test_out_of_range();
      test_random_w0();
      test_back_to_back();
      test_abort();
      test_random_w3();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
